freq_gen_ctrl: RTL and testbench

- Run/stop and configuration controller for a 4-channel square-wave generator.
- Each channel has a programmable half-period, counted in clk cycles.
- Outputs are the waves plus one-cycle rising-edge tick strobes.
- Sits between board-level control (buttons/bus) and the LED/timebase consumers. Reset defaults are the 0.1/1/10/100 Hz timebase.

---
 rtl/freq_gen_pkg.sv | 34 +++
 rtl/freq_gen_chan.sv | 64 ++++++
 rtl/freq_gen_ctrl.sv | 100 ++++++++++
 tb/tb_freq_gen_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/freq_gen_pkg.sv
// Shared types and default timebase constants for the 4-channel square-wave generator.
package freq_gen_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int CH_IDX_W = 2;

  function automatic int unsigned div_01hz(input int unsigned clk_hz);
    return clk_hz * 5;
  endfunction

  function automatic int unsigned div_1hz(input int unsigned clk_hz);
    return clk_hz / 2;
  endfunction

  function automatic int unsigned div_10hz(input int unsigned clk_hz);
    return clk_hz / 20;
  endfunction

  function automatic int unsigned div_100hz(input int unsigned clk_hz);
    return clk_hz / 200;
  endfunction

  // Reset half-period of channel ch: 0.1 / 1 / 10 / 100 Hz timebase.
  function automatic int unsigned def_half(input int ch, input int unsigned clk_hz);
    case (ch)
      0:       return div_01hz(clk_hz);
      1:       return div_1hz(clk_hz);
      2:       return div_10hz(clk_hz);
      default: return div_100hz(clk_hz);
    endcase
  endfunction

endpackage

// File: rtl/freq_gen_chan.sv
// One generator channel: half-period counter, active/shadow half registers, wave toggle and rising-edge tick.
module freq_gen_chan
  import freq_gen_pkg::*;
#(
  parameter int            W        = 30,
  parameter logic [W-1:0]  HALF_RST = W'(1)
) (
  input  logic         i_clk,
  input  logic         i_rs_n,
  input  logic         i_run,
  input  logic         i_clear,
  input  logic         i_load_now,
  input  logic         i_load_shadow,
  input  logic [W-1:0] i_half_in,
  output logic         o_wave,
  output logic         o_tick
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] r_half;
  logic [W-1:0] r_shadow;
  logic         r_wave;
  logic         r_tick;
  logic         w_last;
  logic         w_count;

  assign w_last  = (r_cnt == r_half - W'(1));
  assign w_count = i_run && !i_clear;

  always_ff @(posedge i_clk or negedge i_rs_n) begin
    if (!i_rs_n) begin
      r_cnt    <= '0;
      r_half   <= HALF_RST;
      r_shadow <= HALF_RST;
      r_wave   <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      if (i_load_shadow) r_shadow <= i_half_in;

      // A wrap picks up the shadow as it stood before this edge's write.
      if (i_load_now)
        r_half <= i_half_in;
      else if (w_count && w_last)
        r_half <= r_shadow;

      if (!w_count) begin
        r_cnt  <= '0;
        r_wave <= 1'b0;
        r_tick <= 1'b0;
      end else if (w_last) begin
        r_cnt  <= '0;
        r_wave <= ~r_wave;
        r_tick <= ~r_wave;
      end else begin
        r_cnt  <= r_cnt + W'(1);
        r_tick <= 1'b0;
      end
    end
  end

  assign o_wave = r_wave;
  assign o_tick = r_tick;

endmodule

// File: rtl/freq_gen_ctrl.sv
// Run/stop FSM, config write decode and clamp for the 4-channel generator.
// Optional FREQ_GEN_CH_MASK_EN adds per-channel enables (ch_en).
module freq_gen_ctrl
  import freq_gen_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int          W      = 30,
  parameter int          NCH    = 4
) (
  input  logic                clk,
  input  logic                rs_n,
  input  logic                start,
  input  logic                stop,
  input  logic                cfg_we,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [W-1:0]        cfg_half,
`ifdef FREQ_GEN_CH_MASK_EN
  input  logic [NCH-1:0]      ch_en,
`endif
  output logic                cfg_ack,
  output logic                busy,
  output logic [NCH-1:0]      wave,
  output logic [NCH-1:0]      tick
);

  state_t         r_state;
  logic           r_busy;
  logic           r_cfg_ack;
  logic [W-1:0]   w_half_clamped;
  logic [NCH-1:0] w_run;

  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_cfg_ack <= 1'b0;
    end else begin
      r_cfg_ack <= cfg_we;
      case (r_state)
        IDLE: begin
          if (start && !stop) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Zero would never satisfy cnt == half-1; the fastest legal rate is a toggle every cycle.
  assign w_half_clamped = (cfg_half == '0) ? W'(1) : cfg_half;

`ifdef FREQ_GEN_CH_MASK_EN
  // Enables are registered so a re-enabled channel's first rise lands half clocks after it is sampled.
  logic [NCH-1:0] r_en;

  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) r_en <= '1;
    else       r_en <= ch_en;
  end

  assign w_run = {NCH{r_state == RUN}} & r_en;
`else
  assign w_run = {NCH{r_state == RUN}};
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic w_sel;
    assign w_sel = cfg_we && (cfg_ch == CH_IDX_W'(i));

    freq_gen_chan #(
      .W        (W),
      .HALF_RST (W'(def_half(i, CLK_HZ)))
    ) u_chan (
      .i_clk         (clk),
      .i_rs_n        (rs_n),
      .i_run         (w_run[i]),
      .i_clear       (stop),
      .i_load_now    (w_sel && (r_state == IDLE)),
      .i_load_shadow (w_sel),
      .i_half_in     (w_half_clamped),
      .o_wave        (wave[i]),
      .o_tick        (tick[i])
    );
  end

  assign cfg_ack = r_cfg_ack;
  assign busy    = r_busy;

endmodule

// File: tb/tb_freq_gen_ctrl.sv
// Randomized bench for freq_gen_ctrl against a deadline-based reference model (CLK_HZ=2000).
module tb_freq_gen_ctrl;

  localparam int unsigned CLK_HZ = 2000;
  localparam int          W      = 30;

  logic         clk = 1'b0;
  logic         rs_n;
  logic         start;
  logic         stop;
  logic         cfg_we;
  logic [1:0]   cfg_ch;
  logic [W-1:0] cfg_half;
  logic         cfg_ack;
  logic         busy;
  logic [3:0]   wave;
  logic [3:0]   tick;
`ifdef FREQ_GEN_CH_MASK_EN
  logic [3:0]   ch_en = 4'hF;
`endif

  freq_gen_ctrl #(.CLK_HZ(CLK_HZ), .W(W), .NCH(4)) dut (
    .clk      (clk),
    .rs_n     (rs_n),
    .start    (start),
    .stop     (stop),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_half (cfg_half),
`ifdef FREQ_GEN_CH_MASK_EN
    .ch_en    (ch_en),
`endif
    .cfg_ack  (cfg_ack),
    .busy     (busy),
    .wave     (wave),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each running channel holds the absolute edge index of its next toggle.
  int unsigned m_act [4];
  int unsigned m_sh  [4];
  int unsigned m_dl  [4];
  bit          m_lvl [4];
  bit          m_tick[4];
  bit          m_run;
  bit          m_ack;
  int unsigned cyc;

  task automatic model_reset();
    m_act[0] = CLK_HZ * 5;   m_act[1] = CLK_HZ / 2;
    m_act[2] = CLK_HZ / 20;  m_act[3] = CLK_HZ / 200;
    for (int i = 0; i < 4; i++) begin
      m_sh[i] = m_act[i]; m_dl[i] = 0; m_lvl[i] = 0; m_tick[i] = 0;
    end
    m_run = 0;
    m_ack = 0;
  endtask

  task automatic model_edge();
    int unsigned v;
    v = (cfg_half == '0) ? 1 : int'(cfg_half);
    m_ack = cfg_we;
    if (m_run) begin
      if (stop) begin
        m_run = 0;
        for (int i = 0; i < 4; i++) begin m_lvl[i] = 0; m_tick[i] = 0; end
      end else begin
        for (int i = 0; i < 4; i++) begin
          m_tick[i] = 0;
          if (cyc == m_dl[i]) begin
            m_tick[i] = !m_lvl[i];
            m_lvl[i]  = !m_lvl[i];
            m_act[i]  = m_sh[i];
            m_dl[i]   = cyc + m_act[i];
          end
        end
      end
      if (cfg_we) m_sh[cfg_ch] = v;
    end else begin
      for (int i = 0; i < 4; i++) begin m_lvl[i] = 0; m_tick[i] = 0; end
      if (cfg_we) begin m_sh[cfg_ch] = v; m_act[cfg_ch] = v; end
      if (start && !stop) begin
        m_run = 1;
        for (int i = 0; i < 4; i++) m_dl[i] = cyc + m_act[i];
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] ew;
    logic [3:0] et;
    for (int i = 0; i < 4; i++) begin ew[i] = m_lvl[i]; et[i] = m_tick[i]; end
    chk_val("busy",    32'(busy),    32'(m_run));
    chk_val("cfg_ack", 32'(cfg_ack), 32'(m_ack));
    chk_val("wave",    32'(wave),    32'(ew));
    chk_val("tick",    32'(tick),    32'(et));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic drive(input bit s, input bit p, input bit we, input int ch, input int h);
    start    = s;
    stop     = p;
    cfg_we   = we;
    cfg_ch   = 2'(ch);
    cfg_half = W'(h);
    step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    rs_n = 1'b0; start = 0; stop = 0; cfg_we = 0; cfg_ch = 0; cfg_half = '0;
    cyc = 0;
    model_reset();
    #23;
    compare_all();
    rs_n = 1'b1;
    #1;

    idle(5);
    drive(1, 0, 0, 0, 0);
    idle(33);
    drive(0, 0, 1, 3, 4);
    idle(40);
    idle(420);

    // Stop while wave[3] is high.
    for (int k = 0; k < 60 && !m_lvl[3]; k++) idle(1);
    chk_val("wave3_high_before_stop", 32'(wave[3]), 32'd1);
    idle(1);
    drive(0, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    idle(5);

    drive(0, 0, 1, 2, 0);
    drive(1, 0, 0, 0, 0);
    idle(20);

    // Asynchronous reset in the middle of a run.
    #3;
    rs_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rs_n = 1'b1;
    idle(15);

    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(19) == 0), ($urandom_range(149) == 0),
            ($urandom_range(7) == 0), int'($urandom_range(3)), int'($urandom_range(20)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
